// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: controller
// state encoding, accumulator sizing and output saturation limits.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    ACT
  } state_t;

  localparam int unsigned FRAC_DEFAULT = 4;

  // Wide enough to sum n full-width products plus a shifted bias without overflow
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  function automatic longint sat_hi(input int unsigned dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/neuron_activation.sv
// Output activation: arithmetic rescale by FRAC, optional ReLU, then
// saturation to the signed DW range. Purely combinational.
// Build option: define NEURON_RELU_EN to clamp negative results to zero.
module neuron_activation
  import nn_pkg::*;
#(
  parameter int unsigned AW   = 20,
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = FRAC_DEFAULT
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] y
);

  localparam logic signed [AW-1:0] Hi = AW'(sat_hi(DW));

  logic signed [AW-1:0] shifted;

  // Rescale, activate and clamp the accumulator to the output width
  always_comb begin
    shifted = acc >>> FRAC;
`ifdef NEURON_RELU_EN
    if (shifted[AW-1]) begin
      y = '0;
    end else if (shifted > Hi) begin
      y = Hi[DW-1:0];
    end else begin
      y = shifted[DW-1:0];
    end
`else
    if (shifted > Hi) begin
      y = Hi[DW-1:0];
    end else if (shifted < AW'(sat_lo(DW))) begin
      y = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y = shifted[DW-1:0];
    end
`endif
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single neuron: on start, walks N input/weight pairs through a shared read
// address, multiply-accumulates them onto the bias, activates and holds the
// result with ready high until the next start.
// Build option: NEURON_RELU_EN selects ReLU activation (default linear).
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = FRAC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_i,
  input  logic [1:0]             s_w,
  input  logic signed [DW-1:0]   bias,
  input  logic signed [DW-1:0]   x_data,
  input  logic signed [DW-1:0]   w_data,
  output logic [$clog2(N)-1:0]   rd_addr,
  output logic                   in_sel,
  output logic [1:0]             w_bank,
  output logic                   busy,
  output logic                   ready,
  output logic signed [DW-1:0]   y
);

  localparam int unsigned AddrW = $clog2(N);
  localparam int unsigned AW    = acc_width(DW, N);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(N - 1);

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic signed [2*DW-1:0]  x_ext;
  logic signed [2*DW-1:0]  w_ext;
  logic signed [2*DW-1:0]  prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    bias_ext;
  logic signed [DW-1:0]    act_y;

  assign x_ext    = {{DW{x_data[DW-1]}}, x_data};
  assign w_ext    = {{DW{w_data[DW-1]}}, w_data};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(AW-DW){bias[DW-1]}}, bias};

  neuron_activation #(
    .AW   (AW),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_act (
    .acc (acc),
    .y   (act_y)
  );

  // Handshake FSM with the accumulator and all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      rd_addr <= '0;
      in_sel  <= 1'b0;
      w_bank  <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      y       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            in_sel  <= s_i;
            w_bank  <= s_w;
            acc     <= bias_ext <<< FRAC;
            rd_addr <= '0;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end
        end
        FETCH: begin
          // Read data lags the address by one cycle, so address 0 has no product yet
          if (rd_addr != '0) begin
            acc <= acc + prod_ext;
          end
          if (rd_addr == LastAddr) begin
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + AddrW'(1);
          end
        end
        DRAIN: begin
          acc   <= acc + prod_ext;
          state <= ACT;
        end
        ACT: begin
          y     <= act_y;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
